// File: rtl/mrd_rdx2345_wrback.sv
// Write-back stage after the radix-2/3/4/5 DFT + twiddle: routes up to five tagged lanes
// onto the five data-memory bank write ports, counts stage beats and flags routing errors.
module mrd_rdx2345_wrback #(
   parameter int wData = 30,
   parameter int wAddr = 8,
   parameter int wCnt  = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [wCnt-1:0]      cnt_target,
   input  logic [2:0]           in_factor,
   input  logic                 in_valid,
   input  logic [14:0]          in_bank_index,
   input  logic [5*wAddr-1:0]   in_bank_addr,
   input  logic [5*wData-1:0]   in_real,
   input  logic [5*wData-1:0]   in_imag,
   output logic [4:0]           wr_en,
   output logic [5*wAddr-1:0]   wr_addr,
   output logic [5*wData-1:0]   wr_real,
   output logic [5*wData-1:0]   wr_imag,
   output logic                 busy,
   output logic                 stage_done,
   output logic                 err
);

   localparam int unsigned NL = 5;

   logic                 p1_valid;
   logic                 p1_last;
   logic [2:0]           p1_factor;
   logic [14:0]          p1_idx;
   logic [5*wAddr-1:0]   p1_addr;
   logic [5*wData-1:0]   p1_real;
   logic [5*wData-1:0]   p1_imag;

   logic [wCnt-1:0]      cnt;
   logic [wCnt-1:0]      target;
   logic [wCnt-1:0]      cnt_inc;
   logic                 armed;
   logic                 last_in;

   logic                 factor_ok;
   logic                 bad;
   logic [2:0]           lane_idx [NL];
   logic [NL-1:0]        active;
   logic [NL-1:0]        en_d;
   logic [5*wAddr-1:0]   addr_d;
   logic [5*wData-1:0]   real_d;
   logic [5*wData-1:0]   imag_d;

   // A zero target produces a data-less "last" token so done keeps the normal 2-cycle latency.
   always_comb begin
      cnt_inc = cnt + wCnt'(1);
      if (start)
         last_in = (cnt_target == '0) || (in_valid && (cnt_target == wCnt'(1)));
      else
         last_in = armed && in_valid && (cnt_inc == target);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_valid  <= 1'b0;
         p1_last   <= 1'b0;
         p1_factor <= '0;
         p1_idx    <= '0;
         p1_addr   <= '0;
         p1_real   <= '0;
         p1_imag   <= '0;
         cnt       <= '0;
         target    <= '0;
         armed     <= 1'b0;
      end else begin
         p1_valid  <= in_valid;
         p1_last   <= last_in;
         p1_factor <= in_factor;
         p1_idx    <= in_bank_index;
         p1_addr   <= in_bank_addr;
         p1_real   <= in_real;
         p1_imag   <= in_imag;
         if (start) begin
            target <= cnt_target;
            cnt    <= in_valid ? wCnt'(1) : '0;
            armed  <= !last_in;
         end else if (armed && in_valid) begin
            cnt    <= cnt_inc;
            armed  <= !last_in;
         end
      end
   end

   // Lowest active lane wins each bank; banks without a winner keep their last address/data.
   always_comb begin
      factor_ok = (p1_factor >= 3'd2) && (p1_factor <= 3'd5);
      for (int unsigned k = 0; k < NL; k++) begin
         lane_idx[k] = p1_idx[(NL-1-k)*3 +: 3];
         active[k]   = p1_valid && factor_ok && (3'(k) < p1_factor);
      end
      en_d   = '0;
      addr_d = wr_addr;
      real_d = wr_real;
      imag_d = wr_imag;
      bad    = p1_valid && !factor_ok;
      for (int unsigned b = 0; b < NL; b++) begin
         for (int unsigned k = 0; k < NL; k++) begin
            if (active[k] && !en_d[b] && (lane_idx[k] == 3'(b))) begin
               en_d[b]                   = 1'b1;
               addr_d[b*wAddr +: wAddr]  = p1_addr[(NL-1-k)*wAddr +: wAddr];
               real_d[b*wData +: wData]  = p1_real[(NL-1-k)*wData +: wData];
               imag_d[b*wData +: wData]  = p1_imag[(NL-1-k)*wData +: wData];
            end
         end
      end
      for (int unsigned k = 0; k < NL; k++) begin
         if (active[k] && (lane_idx[k] > 3'd4))
            bad = 1'b1;
         for (int unsigned j = k + 1; j < NL; j++) begin
            if (active[k] && active[j] && (lane_idx[k] == lane_idx[j]))
               bad = 1'b1;
         end
      end
   end

   // A start kills any done token of the abandoned stage still in the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en      <= '0;
         wr_addr    <= '0;
         wr_real    <= '0;
         wr_imag    <= '0;
         busy       <= 1'b0;
         stage_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         wr_en      <= en_d;
         wr_addr    <= addr_d;
         wr_real    <= real_d;
         wr_imag    <= imag_d;
         stage_done <= p1_last && !start;
         busy       <= start || (busy && !stage_done);
         err        <= start ? 1'b0 : (err || bad);
      end
   end

endmodule

// File: tb/tb_mrd_rdx2345_wrback.sv
// Bench for mrd_rdx2345_wrback: crossbar vector table, stage-count sequences,
// async reset, and a randomized stream against a lane-routing reference model.
module tb_mrd_rdx2345_wrback;
   localparam int wData = 30;
   localparam int wAddr = 8;
   localparam int wCnt  = 12;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [wCnt-1:0]      cnt_target;
   logic [2:0]           in_factor;
   logic                 in_valid;
   logic [14:0]          in_bank_index;
   logic [5*wAddr-1:0]   in_bank_addr;
   logic [5*wData-1:0]   in_real;
   logic [5*wData-1:0]   in_imag;
   logic [4:0]           wr_en;
   logic [5*wAddr-1:0]   wr_addr;
   logic [5*wData-1:0]   wr_real;
   logic [5*wData-1:0]   wr_imag;
   logic                 busy;
   logic                 stage_done;
   logic                 err;

   int checks = 0;
   int errors = 0;

   mrd_rdx2345_wrback #(.wData(wData), .wAddr(wAddr), .wCnt(wCnt)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cnt_target(cnt_target),
      .in_factor(in_factor), .in_valid(in_valid), .in_bank_index(in_bank_index),
      .in_bank_addr(in_bank_addr), .in_real(in_real), .in_imag(in_imag),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_real(wr_real), .wr_imag(wr_imag),
      .busy(busy), .stage_done(stage_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  factor;
      logic [14:0] idx;
      logic [4:0]  en;
      logic        err;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      start         = 1'b0;
      cnt_target    = '0;
      in_valid      = 1'b0;
      in_factor     = '0;
      in_bank_index = '0;
      in_bank_addr  = '0;
      in_real       = '0;
      in_imag       = '0;
   endtask

   // Lane k carries addr = ab+k, real = rb+k, imag = -(rb+k)
   task automatic set_beat(input logic [2:0] f, input logic [14:0] idx, input int ab, input int rb);
      in_valid      = 1'b1;
      in_factor     = f;
      in_bank_index = idx;
      for (int k = 0; k < 5; k++) begin
         in_bank_addr[(4-k)*wAddr +: wAddr] = wAddr'(ab + k);
         in_real[(4-k)*wData +: wData]      = wData'(rb + k);
         in_imag[(4-k)*wData +: wData]      = wData'(-(rb + k));
      end
   endtask

   logic [5*wAddr-1:0] exp_addr;
   logic [5*wData-1:0] exp_real, exp_imag;
   int done_cnt, done_at, wr_cycles, busy_cnt;

   // random-section model state
   logic [wAddr-1:0] h_addr [5];
   logic [wData-1:0] h_re [5], h_im [5];
   logic [wAddr-1:0] ra [5];
   logic [wData-1:0] rr [5], ri [5];
   int               idx [5];
   int               hits [5];
   logic [4:0]       prev_en, cur_en;
   logic [5*wAddr-1:0] prev_addr;
   logic [5*wData-1:0] prev_re, prev_im;
   logic             prev_bad, cur_bad, em;

   initial begin
      vecs[0]  = '{3'd5, {3'd4,3'd3,3'd2,3'd1,3'd0}, 5'b11111, 1'b0};
      vecs[1]  = '{3'd3, {3'd0,3'd1,3'd2,3'd0,3'd0}, 5'b00111, 1'b0};
      vecs[2]  = '{3'd4, {3'd2,3'd2,3'd3,3'd7,3'd0}, 5'b01100, 1'b1};
      vecs[3]  = '{3'd2, {3'd5,3'd1,3'd1,3'd1,3'd1}, 5'b00010, 1'b1};
      vecs[4]  = '{3'd6, {3'd0,3'd1,3'd2,3'd3,3'd4}, 5'b00000, 1'b1};
      vecs[5]  = '{3'd1, {3'd0,3'd1,3'd2,3'd3,3'd4}, 5'b00000, 1'b1};
      vecs[6]  = '{3'd0, {3'd0,3'd1,3'd2,3'd3,3'd4}, 5'b00000, 1'b1};
      vecs[7]  = '{3'd2, {3'd3,3'd3,3'd0,3'd1,3'd2}, 5'b01000, 1'b1};
      vecs[8]  = '{3'd5, {3'd0,3'd0,3'd0,3'd0,3'd0}, 5'b00001, 1'b1};
      vecs[9]  = '{3'd4, {3'd1,3'd0,3'd3,3'd2,3'd7}, 5'b01111, 1'b0};
      vecs[10] = '{3'd2, {3'd4,3'd0,3'd7,3'd7,3'd7}, 5'b10001, 1'b0};
      vecs[11] = '{3'd7, {3'd0,3'd1,3'd2,3'd3,3'd4}, 5'b00000, 1'b1};
      vecs[12] = '{3'd5, {3'd1,3'd2,3'd3,3'd4,3'd6}, 5'b11110, 1'b1};

      // reset state
      clear_in();
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_wr_en", 160'(wr_en), 160'(0));
      chk("rst_busy", 160'(busy), 160'(0));
      chk("rst_done", 160'(stage_done), 160'(0));
      chk("rst_err", 160'(err), 160'(0));
      chk("rst_addr", 160'(wr_addr), 160'(0));
      #2 rst_n = 1'b1;
      tick();

      // basic route, radix 5
      start = 1'b1; cnt_target = 12'd1;
      tick();
      chk("basic_busy", 160'(busy), 160'(1));
      start = 1'b0;
      set_beat(3'd5, {3'd4,3'd3,3'd2,3'd1,3'd0}, 10, 100);
      tick();
      clear_in();
      tick();
      for (int b = 0; b < 5; b++) begin
         exp_addr[b*wAddr +: wAddr] = wAddr'(14 - b);
         exp_real[b*wData +: wData] = wData'(104 - b);
         exp_imag[b*wData +: wData] = wData'(-(104 - b));
      end
      chk("basic_en", 160'(wr_en), 160'(5'b11111));
      chk("basic_addr", 160'(wr_addr), 160'(exp_addr));
      chk("basic_real", 160'(wr_real), 160'(exp_real));
      chk("basic_imag", 160'(wr_imag), 160'(exp_imag));
      chk("basic_done", 160'(stage_done), 160'(1));
      chk("basic_err", 160'(err), 160'(0));
      tick();
      chk("basic_done_clr", 160'(stage_done), 160'(0));
      chk("basic_busy_clr", 160'(busy), 160'(0));

      // crossbar vector table (start and beat in the same cycle, target 1)
      for (int i = 0; i < 13; i++) begin
         start = 1'b1; cnt_target = 12'd1;
         set_beat(vecs[i].factor, vecs[i].idx, 32 + 8*i, 1000 + 16*i);
         tick();
         chk("vec_err_clr", 160'(err), 160'(0));
         chk("vec_busy", 160'(busy), 160'(1));
         clear_in();
         tick();
         chk($sformatf("vec%0d_en", i), 160'(wr_en), 160'(vecs[i].en));
         chk($sformatf("vec%0d_err", i), 160'(err), 160'(vecs[i].err));
         chk($sformatf("vec%0d_done", i), 160'(stage_done), 160'(1));
         tick();
         chk($sformatf("vec%0d_err_hold", i), 160'(err), 160'(vecs[i].err));
         chk($sformatf("vec%0d_busy_clr", i), 160'(busy), 160'(0));
         chk($sformatf("vec%0d_en_idle", i), 160'(wr_en), 160'(0));
      end

      // stage count: target 4, beats in cycles 1,2,5,7
      done_cnt = 0; done_at = -1; wr_cycles = 0;
      for (int i = 0; i < 12; i++) begin
         clear_in();
         start = (i == 0); cnt_target = 12'd4;
         if (i == 1 || i == 2 || i == 5 || i == 7) set_beat(3'd2, {3'd0,3'd1,3'd0,3'd0,3'd0}, 0, 0);
         tick();
         if (stage_done) begin done_cnt++; done_at = i; end
         if (wr_en != 0) wr_cycles++;
         if (i == 8) chk("cnt_busy_at_done", 160'(busy), 160'(1));
         if (i == 9) chk("cnt_busy_after", 160'(busy), 160'(0));
      end
      chk("cnt_done_count", 160'(done_cnt), 160'(1));
      chk("cnt_done_cycle", 160'(done_at), 160'(8));
      chk("cnt_writes", 160'(wr_cycles), 160'(4));

      // restart: target 3 with 2 beats, then start with target 0
      done_cnt = 0; done_at = -1; wr_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         clear_in();
         start = (i == 0 || i == 3);
         cnt_target = (i == 0) ? 12'd3 : 12'd0;
         if (i == 1 || i == 2) set_beat(3'd2, {3'd0,3'd1,3'd0,3'd0,3'd0}, 0, 0);
         tick();
         if (stage_done) begin done_cnt++; done_at = i; end
         if (wr_en != 0) wr_cycles++;
         if (i == 5) chk("rs_busy_clr", 160'(busy), 160'(0));
      end
      chk("rs_done_count", 160'(done_cnt), 160'(1));
      chk("rs_done_cycle", 160'(done_at), 160'(4));
      chk("rs_writes", 160'(wr_cycles), 160'(2));

      // zero target from idle: busy exactly 2 cycles
      done_cnt = 0; done_at = -1; wr_cycles = 0; busy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         clear_in();
         start = (i == 0);
         tick();
         if (stage_done) begin done_cnt++; done_at = i; end
         if (wr_en != 0) wr_cycles++;
         if (busy) busy_cnt++;
      end
      chk("z_done_cycle", 160'(done_at), 160'(1));
      chk("z_done_count", 160'(done_cnt), 160'(1));
      chk("z_busy_cycles", 160'(busy_cnt), 160'(2));
      chk("z_writes", 160'(wr_cycles), 160'(0));

      // async reset with a beat in flight
      clear_in();
      start = 1'b1; cnt_target = 12'd2;
      set_beat(3'd2, {3'd1,3'd1,3'd0,3'd0,3'd0}, 0, 0);
      tick();
      clear_in();
      set_beat(3'd2, {3'd0,3'd1,3'd0,3'd0,3'd0}, 0, 0);
      tick();
      clear_in();
      chk("ar_pre_en", 160'(wr_en), 160'(5'b00010));
      chk("ar_pre_err", 160'(err), 160'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("ar_en", 160'(wr_en), 160'(0));
      chk("ar_busy", 160'(busy), 160'(0));
      chk("ar_done", 160'(stage_done), 160'(0));
      chk("ar_err", 160'(err), 160'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ar_post_en", 160'(wr_en), 160'(0));
         chk("ar_post_done", 160'(stage_done), 160'(0));
      end

      // randomized stream against the routing model
      for (int b = 0; b < 5; b++) begin h_addr[b] = '0; h_re[b] = '0; h_im[b] = '0; end
      prev_en = '0; prev_addr = '0; prev_re = '0; prev_im = '0; prev_bad = 1'b0; em = 1'b0;
      for (int i = 0; i < 300; i++) begin
         int f;
         logic v;
         clear_in();
         start = ((i % 40) == 0);
         cnt_target = 12'd4000;
         v = (($urandom % 4) != 0);
         f = (($urandom % 8) == 0) ? int'($urandom % 8) : 2 + int'($urandom % 4);
         for (int k = 0; k < 5; k++) idx[k] = k;
         for (int k = 4; k > 0; k--) begin
            int j, t;
            j = int'($urandom_range(k, 0));
            t = idx[k]; idx[k] = idx[j]; idx[j] = t;
         end
         if (($urandom % 6) == 0) idx[$urandom % 5] = int'($urandom % 8);
         in_valid  = v;
         in_factor = 3'(f);
         for (int k = 0; k < 5; k++) begin
            ra[k] = wAddr'($urandom);
            rr[k] = wData'($urandom);
            ri[k] = wData'($urandom);
            in_bank_index[(4-k)*3 +: 3]        = 3'(idx[k]);
            in_bank_addr[(4-k)*wAddr +: wAddr] = ra[k];
            in_real[(4-k)*wData +: wData]      = rr[k];
            in_imag[(4-k)*wData +: wData]      = ri[k];
         end
         // model: lanes below the radix are live, first claimant of a bank wins
         cur_en  = '0;
         cur_bad = v && (f < 2 || f > 5);
         for (int b = 0; b < 5; b++) hits[b] = 0;
         if (v && f >= 2 && f <= 5) begin
            for (int k = 0; k < f; k++) begin
               if (idx[k] > 4) cur_bad = 1'b1;
               else begin
                  hits[idx[k]]++;
                  if (hits[idx[k]] == 1) begin
                     cur_en[idx[k]] = 1'b1;
                     h_addr[idx[k]] = ra[k];
                     h_re[idx[k]]   = rr[k];
                     h_im[idx[k]]   = ri[k];
                  end else cur_bad = 1'b1;
               end
            end
         end
         tick();
         em = start ? 1'b0 : (em | prev_bad);
         chk("rnd_en", 160'(wr_en), 160'(prev_en));
         chk("rnd_addr", 160'(wr_addr), 160'(prev_addr));
         chk("rnd_real", 160'(wr_real), 160'(prev_re));
         chk("rnd_imag", 160'(wr_imag), 160'(prev_im));
         chk("rnd_err", 160'(err), 160'(em));
         chk("rnd_done", 160'(stage_done), 160'(0));
         prev_en  = cur_en;
         prev_bad = cur_bad;
         for (int b = 0; b < 5; b++) begin
            prev_addr[b*wAddr +: wAddr] = h_addr[b];
            prev_re[b*wData +: wData]   = h_re[b];
            prev_im[b*wData +: wData]   = h_im[b];
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
